// File: rtl/rtc_pkg.sv
// Shared constants and Gray-code helper for the RTC counter synchroniser.
// Pure declarations; no logic, no latency.
package rtc_pkg;

    localparam int MODE_TOGGLE   = 0;
    localparam int MODE_GRAY     = 1;
    localparam int CNT_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_MAX = 64;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic logic [CNT_WIDTH_MAX-1:0] gray2bin(input logic [CNT_WIDTH_MAX-1:0] g);
        logic [CNT_WIDTH_MAX-1:0] b;
        b[CNT_WIDTH_MAX-1] = g[CNT_WIDTH_MAX-1];
        for (int i = CNT_WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rtc_sync_cell.sv
// Multi-flop synchroniser, STAGES deep, WIDTH bits wide, all flops reset to 0.
// Latency STAGES pclk cycles; no flow control.
module rtc_sync_cell #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/rtc_cnt_cdc_sync.sv
// Brings the always-on RTC counter into pclk via LSB-toggle or Gray capture, with
// update/wrap strobes, snapshot handshake, sticky alarm and step monitor. Latency SYNC_STAGES+1.
module rtc_cnt_cdc_sync
    import rtc_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_TOGGLE
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [CNT_WIDTH-1:0] aou_cnt,
    input  logic                 snap_req,
    input  logic                 alarm_en,
    input  logic [CNT_WIDTH-1:0] alarm_val,
    input  logic                 alarm_clr,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] cnt_sync,
    output logic                 cnt_valid,
    output logic                 cnt_upd,
    output logic                 cnt_wrap,
    output logic [CNT_WIDTH-1:0] snap_cnt,
    output logic                 snap_ack,
    output logic                 alarm_hit,
    output logic                 seq_err
);

    logic                 upd;
    logic [CNT_WIDTH-1:0] new_val;
    logic                 alarm_set;
    logic                 seq_set;

    generate
        if (MODE == MODE_GRAY) begin : g_gray
            logic [CNT_WIDTH-1:0]     gray_q;
            logic [CNT_WIDTH_MAX-1:0] gray_ext;
            logic [CNT_WIDTH_MAX-1:0] bin_ext;

            rtc_sync_cell #(.WIDTH(CNT_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
                .pclk    (pclk),
                .presetn (presetn),
                .d       (aou_cnt),
                .q       (gray_q)
            );

            always_comb begin
                gray_ext                = '0;
                gray_ext[CNT_WIDTH-1:0] = gray_q;
                bin_ext                 = gray2bin(gray_ext);
            end

            assign new_val = CNT_WIDTH'(bin_ext);
            assign upd     = (new_val != cnt_sync);
        end else begin : g_toggle
            logic tog_q;
            logic tog_hist;

            rtc_sync_cell #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
                .pclk    (pclk),
                .presetn (presetn),
                .d       (aou_cnt[0]),
                .q       (tog_q)
            );

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    tog_hist <= 1'b0;
                end else begin
                    tog_hist <= tog_q;
                end
            end

            // The bus is quasi-static by the time the LSB edge emerges, so sample it raw.
            assign new_val = aou_cnt;
            assign upd     = tog_q ^ tog_hist;
        end
    endgenerate

    assign alarm_set = upd && alarm_en && (new_val == alarm_val);
    assign seq_set   = (MODE == MODE_GRAY) && upd && cnt_valid &&
                       (new_val != cnt_sync + CNT_WIDTH'(1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_sync  <= '0;
            cnt_valid <= 1'b0;
            cnt_upd   <= 1'b0;
            cnt_wrap  <= 1'b0;
            snap_cnt  <= '0;
            snap_ack  <= 1'b0;
            alarm_hit <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            if (upd) begin
                cnt_sync <= new_val;
            end
            cnt_valid <= cnt_valid | upd;
            cnt_upd   <= upd;
            cnt_wrap  <= upd && (&cnt_sync) && (new_val == '0);
            // A snapshot coinciding with an update takes the incoming value.
            if (snap_req) begin
                snap_cnt <= upd ? new_val : cnt_sync;
            end
            snap_ack  <= snap_req;
            alarm_hit <= alarm_set | (alarm_hit & ~alarm_clr);
            seq_err   <= seq_set | (seq_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_rtc_cnt_cdc_sync.sv
// Directed bench: toggle-mode instance (8-bit, 2 stages) and Gray-mode instance (8-bit, 3 stages).
module tb_rtc_cnt_cdc_sync;

    logic       pclk = 1'b0;
    logic       presetn;

    logic [7:0] a0, av0, a1, av1;
    logic       sr0, ae0, ac0, ec0, sr1, ae1, ac1, ec1;
    logic [7:0] cs0, sc0, cs1, sc1;
    logic       cv0, cu0, cw0, sa0, ah0, se0;
    logic       cv1, cu1, cw1, sa1, ah1, se1;

    int n_cmp  = 0;
    int n_err  = 0;
    int wraps0 = 0;
    int w_base;

    always #5 pclk = ~pclk;

    rtc_cnt_cdc_sync #(.CNT_WIDTH(8), .SYNC_STAGES(2), .MODE(0)) u0 (
        .pclk(pclk), .presetn(presetn), .aou_cnt(a0), .snap_req(sr0),
        .alarm_en(ae0), .alarm_val(av0), .alarm_clr(ac0), .err_clr(ec0),
        .cnt_sync(cs0), .cnt_valid(cv0), .cnt_upd(cu0), .cnt_wrap(cw0),
        .snap_cnt(sc0), .snap_ack(sa0), .alarm_hit(ah0), .seq_err(se0)
    );

    rtc_cnt_cdc_sync #(.CNT_WIDTH(8), .SYNC_STAGES(3), .MODE(1)) u1 (
        .pclk(pclk), .presetn(presetn), .aou_cnt(a1), .snap_req(sr1),
        .alarm_en(ae1), .alarm_val(av1), .alarm_clr(ac1), .err_clr(ec1),
        .cnt_sync(cs1), .cnt_valid(cv1), .cnt_upd(cu1), .cnt_wrap(cw1),
        .snap_cnt(sc1), .snap_ack(sa1), .alarm_hit(ah1), .seq_err(se1)
    );

    always @(negedge pclk) begin
        if (cw0) wraps0 <= wraps0 + 1;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Toggle instance: after this returns, outputs show the update cycle.
    task automatic tick0(input logic [7:0] v);
        a0 = v;
        repeat (3) step();
    endtask

    // Gray instance (3 stages): code already Gray-encoded by hand.
    task automatic tick1(input logic [7:0] g);
        a1 = g;
        repeat (4) step();
    endtask

    initial begin
        presetn = 1'b0;
        a0 = '0; av0 = '0; sr0 = 0; ae0 = 0; ac0 = 0; ec0 = 0;
        a1 = '0; av1 = '0; sr1 = 0; ae1 = 0; ac1 = 0; ec1 = 0;
        repeat (2) step();

        chk("rst_cnt0",   cs0, 0);
        chk("rst_valid0", cv0, 0);
        chk("rst_upd0",   cu0, 0);
        chk("rst_wrap0",  cw0, 0);
        chk("rst_snap0",  sc0, 0);
        chk("rst_ack0",   sa0, 0);
        chk("rst_alarm0", ah0, 0);
        chk("rst_seq0",   se0, 0);
        chk("rst_cnt1",   cs1, 0);
        chk("rst_valid1", cv1, 0);
        chk("rst_snap1",  sc1, 0);
        chk("rst_ack1",   sa1, 0);
        chk("rst_alarm1", ah1, 0);
        chk("rst_seq1",   se1, 0);

        presetn = 1'b1;
        repeat (2) step();

        // First toggle update: visible exactly 3 cycles after the change.
        a0 = 8'h01;
        step(); chk("lat_c1_cnt", cs0, 8'h00);
        step(); chk("lat_c2_cnt", cs0, 8'h00); chk("lat_c2_upd", cu0, 0); chk("lat_c2_valid", cv0, 0);
        step(); chk("lat_c3_cnt", cs0, 8'h01); chk("lat_c3_upd", cu0, 1); chk("lat_c3_valid", cv0, 1);
        step(); chk("lat_c4_upd", cu0, 0); chk("lat_c4_valid", cv0, 1);
        repeat (4) step();

        // Wrap strobe
        w_base = wraps0;
        tick0(8'hFE); chk("wr_fe_cnt", cs0, 8'hFE); chk("wr_fe_wrap", cw0, 0); repeat (5) step();
        tick0(8'hFF); chk("wr_ff_wrap", cw0, 0); repeat (5) step();
        chk("wr_cnt_pre", wraps0 - w_base, 0);
        tick0(8'h00); chk("wr_00_cnt", cs0, 8'h00); chk("wr_00_wrap", cw0, 1);
        step(); chk("wr_00_wrap_off", cw0, 0); repeat (4) step();
        tick0(8'h01); repeat (5) step();
        chk("wr_cnt_total", wraps0 - w_base, 1);

        // Alarm
        ae0 = 1; av0 = 8'h20;
        tick0(8'h1E); chk("tog_no_seqerr", se0, 0); repeat (5) step();
        tick0(8'h1F); chk("al_1f", ah0, 0); repeat (5) step();
        a0 = 8'h20; repeat (2) step(); chk("al_pre", ah0, 0);
        step(); chk("al_20_cnt", cs0, 8'h20); chk("al_20_hit", ah0, 1); repeat (5) step();
        tick0(8'h21); chk("al_21_sticky", ah0, 1); repeat (5) step();
        ac0 = 1; step(); ac0 = 0; chk("al_clr", ah0, 0);
        ae0 = 0;
        tick0(8'h20); chk("al_dis_cnt", cs0, 8'h20); chk("al_dis_hit", ah0, 0); repeat (5) step();
        ae0 = 1;
        tick0(8'h21); repeat (5) step();
        a0 = 8'h20; repeat (2) step(); ac0 = 1; step(); ac0 = 0;
        chk("al_set_wins", ah0, 1); repeat (5) step();

        // Snapshot
        tick0(8'h3F); repeat (5) step();
        tick0(8'h40); repeat (5) step();
        a0 = 8'h41; repeat (2) step(); sr0 = 1; step(); sr0 = 0;
        chk("sn_upd_cnt", cs0, 8'h41); chk("sn_upd_snap", sc0, 8'h41); chk("sn_upd_ack", sa0, 1);
        step(); chk("sn_ack_off", sa0, 0); chk("sn_hold", sc0, 8'h41);
        repeat (3) step();
        sr0 = 1; step(); chk("sn_b2b_ack1", sa0, 1); chk("sn_b2b_snap", sc0, 8'h41);
        step(); chk("sn_b2b_ack2", sa0, 1);
        sr0 = 0; step(); chk("sn_b2b_off", sa0, 0); chk("sn_b2b_hold", sc0, 8'h41);

        // Gray mode: 5,6,7 then jumps
        a1 = 8'h07; repeat (3) step(); chk("gr_lat_c3", cs1, 8'h00);
        step(); chk("gr_5_cnt", cs1, 8'h05); chk("gr_5_upd", cu1, 1); chk("gr_5_valid", cv1, 1); chk("gr_5_seq", se1, 0);
        repeat (4) step();
        tick1(8'h05); chk("gr_6_cnt", cs1, 8'h06); chk("gr_6_seq", se1, 0); repeat (4) step();
        tick1(8'h04); chk("gr_7_cnt", cs1, 8'h07); chk("gr_7_seq", se1, 0); repeat (4) step();
        tick1(8'h0F); chk("gr_10_cnt", cs1, 8'h0A); chk("gr_10_seq", se1, 1); repeat (4) step();
        ec1 = 1; step(); ec1 = 0; chk("gr_errclr", se1, 0);
        a1 = 8'h1E; repeat (3) step(); ec1 = 1; step(); ec1 = 0;
        chk("gr_20_cnt", cs1, 8'h14); chk("gr_set_wins", se1, 1); repeat (4) step();
        ec1 = 1; step(); ec1 = 0; chk("gr_errclr2", se1, 0);
        tick1(8'h80); chk("gr_ff_cnt", cs1, 8'hFF); chk("gr_ff_seq", se1, 1); repeat (4) step();
        ec1 = 1; step(); ec1 = 0;
        tick1(8'h00); chk("gr_wrap_cnt", cs1, 8'h00); chk("gr_wrap_pulse", cw1, 1); chk("gr_wrap_seq", se1, 0);
        repeat (4) step();

        // Reset mid-count
        tick0(8'h32); repeat (5) step();
        tick0(8'h33); chk("pr_cnt0", cs0, 8'h33); repeat (5) step();
        tick1(8'h2A); chk("pr_cnt1", cs1, 8'h33); chk("pr_seq1", se1, 1); repeat (4) step();
        presetn = 1'b0; #1;
        chk("ar_cnt0",   cs0, 0);
        chk("ar_valid0", cv0, 0);
        chk("ar_snap0",  sc0, 0);
        chk("ar_alarm0", ah0, 0);
        chk("ar_cnt1",   cs1, 0);
        chk("ar_valid1", cv1, 0);
        chk("ar_seq1",   se1, 0);
        step();
        presetn = 1'b1;
        step(); chk("po_c1_valid0", cv0, 0); chk("po_c1_valid1", cv1, 0);
        step();
        step(); chk("po_c3_cnt0", cs0, 8'h33); chk("po_c3_valid0", cv0, 1);
        step(); chk("po_c4_cnt1", cs1, 8'h33); chk("po_c4_valid1", cv1, 1); chk("po_c4_seq1", se1, 0);
        repeat (4) step();
        tick1(8'h2E); chk("po_34_cnt1", cs1, 8'h34); chk("po_34_seq1", se1, 0);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_cnt_cdc_sync.md
Name: rtc_cnt_cdc_sync

Overview:
Parametrised successor to the RTC counter synchroniser. It transfers the free-running always-on RTC counter into the pclk domain. The capture method is selectable: LSB-toggle or Gray-coded. Capture uses a flop enable, not a gated clock. Adds update/wrap strobes, a coherent snapshot handshake, a sticky alarm compare, and a sequence-error monitor. Sits between the AOU counter and the RTC APB register file.

Parameters:
CNT_WIDTH, 32, counter width in bits (2..64)
SYNC_STAGES, 2, synchroniser flop depth (2..4)
MODE, 0, 0 = LSB-toggle capture of binary counter; 1 = Gray-coded counter, every bit synchronised

Ports:
pclk  input  1  APB/system clock; sole clock of the block
presetn  input  1  reset, asynchronous assert, active-low
aou_cnt  input  CNT_WIDTH  AOU counter; binary when MODE=0, Gray when MODE=1; increments by one per RTC tick
snap_req  input  1  one-cycle request to freeze the current value
alarm_en  input  1  alarm compare enable
alarm_val  input  CNT_WIDTH  alarm match value
alarm_clr  input  1  clears alarm_hit
err_clr  input  1  clears seq_err
cnt_sync  output  CNT_WIDTH  synchronised binary counter value
cnt_valid  output  1  high once the first update has occurred
cnt_upd  output  1  one-cycle pulse when cnt_sync changes
cnt_wrap  output  1  one-cycle pulse on an all-ones -> zero update
snap_cnt  output  CNT_WIDTH  frozen snapshot value
snap_ack  output  1  one-cycle pulse when snap_cnt is loaded
alarm_hit  output  1  sticky match flag
seq_err  output  1  sticky non-unit-step flag (MODE=1 only; tied 0 for MODE=0)

Behaviour:
- Reset: every output and every internal flop is 0.
- Constraint on the source: RTC tick period must be at least SYNC_STAGES+2 pclk cycles. aou_cnt must be stable for at least SYNC_STAGES+1 pclk cycles after each LSB change.
- MODE=0:
  - aou_cnt[0] passes through SYNC_STAGES flops plus one history flop; edge = last sync stage XOR history.
  - On edge, cnt_sync <= aou_cnt (direct sample; quasi-static by the constraint above).
  - Latency from LSB toggle to cnt_sync change: SYNC_STAGES+1 pclk cycles.
- MODE=1:
  - All bits pass through SYNC_STAGES flops, then Gray->binary conversion (combinational XOR prefix).
  - Update when the converted value != cnt_sync. Latency: SYNC_STAGES+1 cycles.
- Update cycle (the cycle cnt_sync is loaded): in that same cycle cnt_upd=1 and cnt_valid is set. cnt_valid then stays set until reset.
- cnt_wrap=1 on an update where old cnt_sync is all-ones and new value is 0.
- Snapshot:
  - snap_req in cycle N: snap_cnt <= the value cnt_sync holds after cycle N. If an update lands in cycle N, the new value is taken.
  - snap_ack pulses in cycle N+1.
  - Back-to-back requests are each acknowledged. snap_cnt holds its value between requests.
- Alarm: alarm_hit sets on an update whose new value == alarm_val while alarm_en=1. No match on non-update cycles. alarm_clr clears it; a simultaneous set wins.
- seq_err (MODE=1): sets on an update with cnt_valid=1 where new != old+1 modulo 2^CNT_WIDTH. The wrap to 0 is legal. The first update after reset is never an error. err_clr clears it; a simultaneous set wins.
- Reset mid-operation: all state clears; the first post-reset edge/difference re-establishes cnt_valid.
- Arithmetic: increment/compare at CNT_WIDTH bits, unsigned, wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package rtc_pkg: MODE_TOGGLE=0 and MODE_GRAY=1 constants, the default CNT_WIDTH, and the Gray->binary function.
- One sub-module, rtc_sync_cell: a SYNC_STAGES-deep, width-parametrised reset-to-0 synchroniser. Instantiated at width 1 for MODE=0 and CNT_WIDTH for MODE=1.

Test Plan:
- MODE=0, SYNC_STAGES=2: aou_cnt 0->1 held 8 pclk -> cnt_sync=1 exactly 3 cycles after change; cnt_upd and cnt_valid assert in that same cycle.
- MODE=0, CNT_WIDTH=8: count 0xFE->0xFF->0x00 -> cnt_wrap pulses once on the 0x00 update; no other wrap pulses.
- MODE=1: Gray sequence for 5,6,7 -> cnt_sync 5,6,7; seq_err stays 0. Then Gray jump 7->10 -> seq_err=1. err_clr alone clears it; err_clr concurrent with another jump leaves it 1.
- alarm_en=1, alarm_val=0x20, count through 0x1F..0x21 -> alarm_hit set in the 0x20 update cycle. alarm_clr clears; alarm_en=0 with a repeat match stays 0.
- snap_req in the same cycle as update 0x40->0x41 -> snap_cnt=0x41, snap_ack next cycle. Later snap_req with no update -> same value, another ack.
- presetn asserted mid-count (cnt_sync=0x33) -> all outputs 0 immediately. After release, the next tick -> cnt_valid=1 and no seq_err.
